// File: rtl/pak_dsp_pkg.sv
// pak_dsp_pkg: shared state encoding, widths and grant ids for the pak_dsp register arbiter
package pak_dsp_pkg;
   localparam int DSP_AW = 6;
   localparam int DATA_W = 14;
   localparam logic [31:0] TIMEOUT_PATTERN = 32'hBAD0_0000;
   localparam logic GNT_WB = 1'b0;
   localparam logic GNT_LA = 1'b1;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
endpackage

// File: rtl/pak_dsp_rr_arb2.sv
// pak_dsp_rr_arb2: two-way round-robin arbiter, pointer moves only when a grant is taken
module pak_dsp_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant
);
   import pak_dsp_pkg::*;
   logic last_q, last_d;
   always_comb begin
      grant  = &req ? ~last_q : req[1];
      last_d = advance ? grant : last_q;
   end
   // reset as if LA was served last so WB wins the first tie
   always_ff @(posedge clk) begin
      if (rst) last_q <= GNT_LA;
      else     last_q <= last_d;
   end
endmodule

// File: rtl/pak_dsp_reg_arbiter.sv
// pak_dsp_reg_arbiter: shares the pak_dsp register port between the WB slave path and the LA debug path
module pak_dsp_reg_arbiter #(
   parameter int DATA_W      = 14,
   parameter int DSP_AW      = 6,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              la_req_i,
   input  logic              la_we_i,
   input  logic [DSP_AW-1:0] la_addr_i,
   input  logic [DATA_W-1:0] la_wdata_i,
   output logic              la_done_o,
   output logic [DATA_W-1:0] la_rdata_o,
   output logic              dsp_req_o,
   output logic              dsp_write_en_o,
   output logic [DSP_AW-1:0] dsp_addr_o,
   output logic [DATA_W-1:0] dsp_wdata_o,
   input  logic [DATA_W-1:0] dsp_rdata_i,
   input  logic              dsp_ack_i,
   output logic              busy_o,
   output logic              err_o
);
   import pak_dsp_pkg::*;
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   state_t            state_q, state_d;
   logic              la_req_q, la_pend_q, la_pend_d;
   logic              la_we_q, la_we_d;
   logic [DSP_AW-1:0] la_addr_q, la_addr_d;
   logic [DATA_W-1:0] la_wdata_q, la_wdata_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [DSP_AW-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              dsp_req_q, dsp_req_d;
   logic              wbs_ack_q, wbs_ack_d;
   logic [31:0]       wbs_dat_q, wbs_dat_d;
   logic              la_done_q, la_done_d;
   logic [DATA_W-1:0] la_rdata_q, la_rdata_d;
   logic              err_q, err_d;
   logic              req0, la_rise, start, grant, tmo, fin;
   logic [DATA_W-1:0] res;
   logic              unused_bits;
   assign unused_bits = ^{wbs_adr_i[31:DSP_AW+2], wbs_adr_i[1:0], wbs_dat_i[31:DATA_W]};
   assign req0    = wbs_cyc_i & wbs_stb_i;
   assign la_rise = la_req_i & ~la_req_q;
   assign start   = (state_q == ST_IDLE) && (req0 || la_pend_q);
   pak_dsp_rr_arb2 u_rr (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .req     ({la_pend_q, req0}),
      .advance (start),
      .grant   (grant)
   );
   always_comb begin
      state_d    = state_q == ST_IDLE  ? (start ? ST_ISSUE : ST_IDLE) :
                   state_q == ST_ISSUE ? ST_WAIT :
                   state_q == ST_WAIT  ? (fin ? ST_DONE : ST_WAIT) : ST_IDLE;
      cnt_d      = state_q == ST_WAIT ? cnt_q + CW'(1) : '0;
      // an ack on the final wait cycle wins over the timeout
      tmo        = (state_q == ST_WAIT) && !dsp_ack_i && (cnt_d == CW'(TIMEOUT_CYC));
      fin        = ((state_q == ST_WAIT) && dsp_ack_i) || tmo;
      res        = (dsp_ack_i && !we_q) ? dsp_rdata_i : '0;
      la_pend_d  = (start && grant == GNT_LA) ? 1'b0 : (la_pend_q | la_rise);
      la_we_d    = (la_rise && !la_pend_q) ? la_we_i    : la_we_q;
      la_addr_d  = (la_rise && !la_pend_q) ? la_addr_i  : la_addr_q;
      la_wdata_d = (la_rise && !la_pend_q) ? la_wdata_i : la_wdata_q;
      gnt_d      = start ? grant : gnt_q;
      we_d       = start ? (grant == GNT_LA ? la_we_q : wbs_we_i) : we_q;
      addr_d     = start ? (grant == GNT_LA ? la_addr_q : wbs_adr_i[DSP_AW+1:2]) : addr_q;
      wdata_d    = start ? (grant == GNT_LA ? la_wdata_q : wbs_dat_i[DATA_W-1:0]) : wdata_q;
      dsp_req_d  = start || (state_q == ST_ISSUE) || ((state_q == ST_WAIT) && !fin);
      wbs_ack_d  = fin && (gnt_q == GNT_WB);
      wbs_dat_d  = wbs_ack_d ? (tmo ? TIMEOUT_PATTERN : 32'(res)) : '0;
      la_done_d  = fin && (gnt_q == GNT_LA);
      la_rdata_d = la_done_d ? res : la_rdata_q;
      err_d      = err_q | tmo;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         la_req_q   <= 1'b0;
         la_pend_q  <= 1'b0;
         la_we_q    <= 1'b0;
         la_addr_q  <= '0;
         la_wdata_q <= '0;
         gnt_q      <= GNT_WB;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         dsp_req_q  <= 1'b0;
         wbs_ack_q  <= 1'b0;
         wbs_dat_q  <= '0;
         la_done_q  <= 1'b0;
         la_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         la_req_q   <= la_req_i;
         la_pend_q  <= la_pend_d;
         la_we_q    <= la_we_d;
         la_addr_q  <= la_addr_d;
         la_wdata_q <= la_wdata_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         dsp_req_q  <= dsp_req_d;
         wbs_ack_q  <= wbs_ack_d;
         wbs_dat_q  <= wbs_dat_d;
         la_done_q  <= la_done_d;
         la_rdata_q <= la_rdata_d;
         err_q      <= err_d;
      end
   end
   assign wbs_ack_o      = wbs_ack_q;
   assign wbs_dat_o      = wbs_dat_q;
   assign la_done_o      = la_done_q;
   assign la_rdata_o     = la_rdata_q;
   assign dsp_req_o      = dsp_req_q;
   assign dsp_write_en_o = we_q;
   assign dsp_addr_o     = addr_q;
   assign dsp_wdata_o    = wdata_q;
   assign busy_o         = state_q != ST_IDLE;
   assign err_o          = err_q;
endmodule

// File: tb/tb_pak_dsp_reg_arbiter.sv
// tb_pak_dsp_reg_arbiter: directed stimulus with a scoreboard of expected WB/LA completions
module tb_pak_dsp_reg_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        la_req_i, la_we_i;
   logic [5:0]  la_addr_i;
   logic [13:0] la_wdata_i;
   logic        la_done_o;
   logic [13:0] la_rdata_o;
   logic        dsp_req_o, dsp_write_en_o;
   logic [5:0]  dsp_addr_o;
   logic [13:0] dsp_wdata_o, dsp_rdata_i;
   logic        dsp_ack_i;
   logic        busy_o, err_o;

   typedef struct {bit la; logic [31:0] data;} exp_t;
   typedef struct {bit we; logic [31:0] adr; logic [31:0] dat;} wb_cmd_t;
   exp_t    q[$];
   wb_cmd_t wb_q[$];
   int      n_chk = 0;
   int      n_fail = 0;
   int      ack_k = 1;
   bit      ack_en = 1'b1;
   int      age = -1;
   logic [13:0] rdata_val = '0;
   exp_t    e;
   wb_cmd_t c;
   logic    prev_ack = 1'b0;
   logic    prev_done = 1'b0;
   int      cnt;

   always #5 clk = ~clk;
   assign dsp_rdata_i = rdata_val;

   pak_dsp_reg_arbiter dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .la_req_i(la_req_i), .la_we_i(la_we_i), .la_addr_i(la_addr_i), .la_wdata_i(la_wdata_i),
      .la_done_o(la_done_o), .la_rdata_o(la_rdata_o),
      .dsp_req_o(dsp_req_o), .dsp_write_en_o(dsp_write_en_o), .dsp_addr_o(dsp_addr_o),
      .dsp_wdata_o(dsp_wdata_o), .dsp_rdata_i(dsp_rdata_i), .dsp_ack_i(dsp_ack_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!busy_o && q.size() == 0 && wb_q.size() == 0 && !wbs_stb_i) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: timed out with %0d expected completions pending", q.size());
   endtask

   task automatic wait_dsp_req(input string name);
      int i;
      for (i = 0; i < 40 && !dsp_req_o; i++) @(negedge clk);
      if (!dsp_req_o) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: dsp_req_o never asserted", name);
      end
   endtask

   // pak_dsp model: ack k cycles after dsp_req_o rises
   initial begin
      dsp_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         age = dsp_req_o ? age + 1 : -1;
         dsp_ack_i = ack_en && dsp_req_o && (age == ack_k);
      end
   end

   // WB master: one command at a time, stb held until ack (or reset)
   initial begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_adr_i = '0; wbs_dat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (wbs_stb_i && (wbs_ack_o || rst)) begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
         end else if (!wbs_stb_i && !rst && wb_q.size() > 0) begin
            c = wb_q.pop_front();
            wbs_we_i = c.we; wbs_adr_i = c.adr; wbs_dat_i = c.dat;
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
         end
      end
   end

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (wbs_ack_o) begin
            check("wb_ack_single_cycle", 32'(prev_ack), 0);
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL wb_unexpected_ack: got wbs_ack_o=1 dat=0x%0h, expected no ack", wbs_dat_o);
            end else begin
               e = q.pop_front();
               check("grant_order_wb", 0, 32'(e.la));
               check("wbs_dat_o", wbs_dat_o, e.data);
            end
         end else if (prev_ack) check("wbs_dat_o_cleared", wbs_dat_o, 0);
         if (la_done_o) begin
            check("la_done_single_cycle", 32'(prev_done), 0);
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL la_unexpected_done: got la_done_o=1 rdata=0x%0h, expected no done", la_rdata_o);
            end else begin
               e = q.pop_front();
               check("grant_order_la", 1, 32'(e.la));
               check("la_rdata_o", 32'(la_rdata_o), e.data);
            end
         end
         prev_ack = wbs_ack_o;
         prev_done = la_done_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      la_req_i = 1'b0; la_we_i = 1'b0; la_addr_i = '0; la_wdata_i = '0;
      tick(3);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_dsp_req", 32'(dsp_req_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_wbs_dat", wbs_dat_o, 0);
      check("rst_la_rdata", 32'(la_rdata_o), 0);
      rst = 1'b0;
      tick(2);

      // WB write, ack after 2 cycles
      ack_en = 1'b1; ack_k = 2;
      wb_q.push_back('{we: 1'b1, adr: 32'h0000_000C, dat: 32'h0000_1234});
      q.push_back('{la: 1'b0, data: 32'h0});
      cnt = 0;
      while (!wbs_stb_i && cnt < 10) begin @(negedge clk); cnt++; end
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!dsp_req_o && cnt < 20);
      check("wr_req_latency", 32'(cnt), 1);
      check("wr_dsp_addr", 32'(dsp_addr_o), 3);
      check("wr_dsp_wdata", 32'(dsp_wdata_o), 32'h1234);
      check("wr_dsp_we", 32'(dsp_write_en_o), 1);
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!wbs_ack_o && cnt < 20);
      check("wr_ack_latency", 32'(cnt), 3);
      wait_idle(20);

      // LA read addr 5, ack after 1 cycle
      ack_k = 1; rdata_val = 14'h2AAA;
      la_we_i = 1'b0; la_addr_i = 6'd5; la_req_i = 1'b1;
      q.push_back('{la: 1'b1, data: 32'h2AAA});
      wait_dsp_req("la_read");
      check("la_dsp_addr", 32'(dsp_addr_o), 5);
      check("la_dsp_we", 32'(dsp_write_en_o), 0);
      wait_idle(20);
      la_req_i = 1'b0;
      tick(3);
      check("la_rdata_held", 32'(la_rdata_o), 32'h2AAA);
      check("la_done_low", 32'(la_done_o), 0);

      // contention: LA, then WB+LA twice, expect LA WB LA WB LA
      ack_k = 3; rdata_val = 14'h0155;
      la_addr_i = 6'd1; la_req_i = 1'b1;
      q.push_back('{la: 1'b1, data: 32'h155});
      wait_dsp_req("rr_first_la");
      la_req_i = 1'b0;
      wb_q.push_back('{we: 1'b0, adr: 32'h0000_0010, dat: 32'h0});
      q.push_back('{la: 1'b0, data: 32'h155});
      tick(1);
      la_addr_i = 6'd2; la_req_i = 1'b1;
      q.push_back('{la: 1'b1, data: 32'h155});
      for (int i = 0; i < 60 && q.size() > 1; i++) @(negedge clk);
      tick(1);
      wait_dsp_req("rr_second_la");
      la_req_i = 1'b0;
      wb_q.push_back('{we: 1'b0, adr: 32'h0000_0014, dat: 32'h0});
      q.push_back('{la: 1'b0, data: 32'h155});
      tick(1);
      la_addr_i = 6'd3; la_req_i = 1'b1;
      q.push_back('{la: 1'b1, data: 32'h155});
      wait_idle(100);

      // la_req_i held high: no retrigger until a fresh edge
      tick(8);
      check("la_held_no_retrigger", 32'(busy_o), 0);
      la_req_i = 1'b0;
      tick(1);
      rdata_val = 14'h0ABC; la_addr_i = 6'd7; la_req_i = 1'b1;
      q.push_back('{la: 1'b1, data: 32'hABC});
      wait_idle(30);
      la_req_i = 1'b0;
      tick(2);

      // timeout: no ack ever
      ack_en = 1'b0;
      check("err_before_timeout", 32'(err_o), 0);
      wb_q.push_back('{we: 1'b0, adr: 32'h0000_0020, dat: 32'h0});
      q.push_back('{la: 1'b0, data: 32'hBAD0_0000});
      wait_dsp_req("timeout_req");
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!wbs_ack_o && cnt < 40);
      check("timeout_latency", 32'(cnt), 16);
      tick(2);
      check("timeout_err", 32'(err_o), 1);
      check("timeout_busy", 32'(busy_o), 0);
      tick(5);
      check("err_sticky", 32'(err_o), 1);

      // reset during WAIT abandons the transaction silently
      wb_q.push_back('{we: 1'b0, adr: 32'h0000_0004, dat: 32'h0});
      wait_dsp_req("reset_req");
      tick(4);
      rst = 1'b1;
      tick(1);
      check("midrst_dsp_req", 32'(dsp_req_o), 0);
      check("midrst_busy", 32'(busy_o), 0);
      check("midrst_err", 32'(err_o), 0);
      check("midrst_la_rdata", 32'(la_rdata_o), 0);
      check("midrst_dsp_addr", 32'(dsp_addr_o), 0);
      rst = 1'b0;
      tick(2);
      ack_en = 1'b1; ack_k = 2; rdata_val = 14'h0777;
      wb_q.push_back('{we: 1'b0, adr: 32'h0000_0008, dat: 32'h0});
      q.push_back('{la: 1'b0, data: 32'h777});
      wait_dsp_req("post_reset_req");
      check("post_reset_addr", 32'(dsp_addr_o), 2);
      wait_idle(30);
      tick(3);
      check("scoreboard_drained", 32'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
